// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver: oversamples bclk/ws/sd in the clk domain, deserialises
// each slot MSB first and emits a left/right pair with a one-cycle valid strobe.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i2s_bclk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    frame_error,
    output logic                    locked
);

    typedef enum logic [1:0] {
        UNLOCKED,
        ALIGNING,
        LOCKED
    } state_t;

    localparam logic [5:0] LP_KEEP_BITS = 6'(SAMPLE_WIDTH);
    localparam logic [5:0] LP_SLOT_BITS = 6'(SLOT_BITS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_bclk_sync;
    logic [1:0]              r_ws_sync;
    logic [1:0]              r_sd_sync;
    logic                    r_bclk_d;
    logic                    r_ws_prev;
    logic                    r_ws_seen;
    logic [5:0]              r_bit_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic                    r_hold_valid;
    logic [SAMPLE_WIDTH-1:0] r_left_sample;
    logic [SAMPLE_WIDTH-1:0] r_right_sample;
    logic                    r_sample_valid;
    logic                    r_frame_error;

    logic                    w_rise;
    logic                    w_ws;
    logic                    w_sd;
    logic                    w_boundary;
    logic [5:0]              w_cnt_inc;
    logic                    w_slot_ok;
    logic                    w_left_end;
    logic                    w_load_left;
    logic                    w_load_pair;
    logic                    w_err;
    logic                    w_drop_hold;

    assign w_rise     = r_bclk_sync[1] & ~r_bclk_d;
    assign w_ws       = r_ws_sync[1];
    assign w_sd       = r_sd_sync[1];
    // The very first sampled ws after reset only seeds r_ws_prev; it is not a boundary.
    assign w_boundary = w_rise & r_ws_seen & (w_ws != r_ws_prev);
    assign w_cnt_inc  = (r_bit_cnt == 6'd63) ? r_bit_cnt : r_bit_cnt + 6'd1;
    assign w_slot_ok  = (w_cnt_inc == LP_SLOT_BITS);
    assign w_left_end = ~r_ws_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bclk_sync <= 2'b00;
            r_ws_sync   <= 2'b00;
            r_sd_sync   <= 2'b00;
            r_bclk_d    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i2s_bclk};
            r_ws_sync   <= {r_ws_sync[0], i2s_ws};
            r_sd_sync   <= {r_sd_sync[0], i2s_sd};
            r_bclk_d    <= r_bclk_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_left  = 1'b0;
        w_load_pair  = 1'b0;
        w_err        = 1'b0;
        w_drop_hold  = 1'b0;
        if (w_boundary) begin
            case (r_state)
                UNLOCKED: begin
                    w_next_state = ALIGNING;
                    w_drop_hold  = 1'b1;
                end
                ALIGNING: begin
                    w_drop_hold = 1'b1;
                    if (w_slot_ok) begin
                        w_next_state = LOCKED;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_slot_ok) begin
                        w_err        = 1'b1;
                        w_drop_hold  = 1'b1;
                        w_next_state = ALIGNING;
                    end else if (w_left_end) begin
                        w_load_left = 1'b1;
                    end else begin
                        w_load_pair = r_hold_valid;
                        w_drop_hold = 1'b1;
                    end
                end
                default: w_next_state = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ws_prev      <= 1'b0;
            r_ws_seen      <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_left_hold    <= '0;
            r_hold_valid   <= 1'b0;
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_sample_valid <= w_load_pair;
            r_frame_error  <= w_err;
            if (w_rise) begin
                r_ws_prev <= w_ws;
                r_ws_seen <= 1'b1;
                if (r_bit_cnt < LP_KEEP_BITS) begin
                    r_shift <= {r_shift[SAMPLE_WIDTH-2:0], w_sd};
                end
                r_bit_cnt <= w_boundary ? 6'd0 : w_cnt_inc;
            end
            if (w_load_left) begin
                r_left_hold  <= r_shift;
                r_hold_valid <= 1'b1;
            end else if (w_drop_hold) begin
                r_hold_valid <= 1'b0;
            end
            // The boundary bit of a good slot lies past SAMPLE_WIDTH, so r_shift is final here.
            if (w_load_pair) begin
                r_left_sample  <= r_left_hold;
                r_right_sample <= r_shift;
            end
        end
    end

    assign left_sample  = r_left_sample;
    assign right_sample = r_right_sample;
    assign sample_valid = r_sample_valid;
    assign frame_error  = r_frame_error;
    assign locked       = (r_state == LOCKED);

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
Slave-mode I2S receiver: samples externally driven bit clock, word select and serial data in the master_clk domain, deserialises each slot MSB-first and presents a left/right sample pair with a one-cycle valid strobe. It is the receive-side counterpart of i2s_transmitter, used for audio input and for loopback checking of the synth output. Frame format matches the transmitter: 48 kHz frames, 64 bit clocks per frame, 32-bit slots, standard I2S one-bit WS delay.

Parameters:
SAMPLE_WIDTH, 16, bits kept per channel (the first SAMPLE_WIDTH bits of each slot, MSB first)
SLOT_BITS, 32, required bit clocks per slot; any other slot length is a framing error

Ports:
clk  input  1  system clock (12.288 MHz); must be at least 4x i2s_bclk
rst  input  1  reset, asynchronous, active-low
i2s_bclk  input  1  serial bit clock, asynchronous to clk
i2s_ws  input  1  word select, 0 = left, 1 = right; changes on bclk falling edge
i2s_sd  input  1  serial data, MSB first, changes on bclk falling edge
left_sample  output  SAMPLE_WIDTH  last complete left sample
right_sample  output  SAMPLE_WIDTH  last complete right sample
sample_valid  output  1  one-clk pulse when a new left/right pair is loaded
frame_error  output  1  one-clk pulse on slot length mismatch
locked  output  1  high while frame alignment is established

Behaviour:
- Reset (rst low, async): all outputs 0; synchronisers, shift register, bit counter and left hold register cleared; state UNLOCKED.
- Input path: i2s_bclk, i2s_ws and i2s_sd each pass through a 2-FF synchroniser. A third bclk register detects rising edges. ws and sd are sampled only on a detected rising edge.
- Per rising edge: shift sd into the slot register while bit_cnt < SAMPLE_WIDTH. Increment bit_cnt, which saturates at 63 (6 bits).
- Boundary: the sampled ws differs from the previously sampled ws. The bit sampled at this edge is the LSB of the ending slot and counts toward it. After evaluating the slot, bit_cnt returns to 0 and channel takes the new ws value. The next edge carries the MSB of the new slot.
- Slot OK means bit_cnt equals SLOT_BITS after counting the boundary bit.
- States:
  - UNLOCKED: ignore data. On the first boundary go to ALIGNING. The partial slot in progress is discarded.
  - ALIGNING: at the next boundary, if the slot is OK go to LOCKED; otherwise stay in ALIGNING and pulse frame_error.
  - LOCKED: locked = 1.
- LOCKED, left slot ends (ws 0->1):
  - Slot OK: copy the slot register into left_hold.
  - Slot not OK: frame_error pulse, locked = 0, go to ALIGNING, discard the pair.
- LOCKED, right slot ends (ws 1->0):
  - Slot OK and left_hold valid for this frame: load left_sample = left_hold and right_sample = slot register in the same clk, and pulse sample_valid.
  - Slot not OK: handle as for a bad left slot.
- Outputs hold their values between updates. sample_valid and frame_error are never high in the same cycle.
- Latency: sample_valid is high in the clk cycle after the boundary edge is detected. This is at most 5 clk after the i2s_bclk pin rises.
- Bits after SAMPLE_WIDTH in a slot are ignored; no rounding.
- bclk stopped: no edges, so state freezes and no pulses are generated.
- Reset mid-frame: immediate return to reset state. The first post-reset valid pair needs one full aligning slot and then a complete left+right frame.

Test Plan:
- Reset, then 3 frames of left=0x1234_0000, right=0xABCD_0000 with 32-bit slots. Required: locked rises at the end of the first full aligning slot. Exactly one sample_valid per subsequent complete frame with left_sample=0x1234, right_sample=0xABCD. No frame_error.
- Slot data left=0x8000_FFFF, right=0x7FFF_0001. Required: left_sample=0x8000, right_sample=0x7FFF; truncation only.
- While locked, send a 31-bit right slot. Required: one frame_error pulse, locked=0, no sample_valid for that frame, left/right outputs unchanged. Then 2 good frames: locked returns and sample_valid resumes with correct data.
- While locked, send a 33-bit left slot. Required: frame_error pulse, pair discarded, recovery as in the previous scenario.
- Assert rst mid-right-slot. Required: all outputs 0 asynchronously. After release, the first sample_valid comes only after an aligning slot plus a full good frame.
- clk:bclk ratio exactly 4:1 (12.288 MHz : 3.072 MHz) with random bclk phase. Required: no missed or double edges over 100 frames, and received data equals transmitted data.
